// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Purpose  : Shared state encoding and default constants for the JK latch
//            output monitor and its synchroniser.
// Revision : 1.0  initial release
// ============================================================================
package jk_pkg;

    // Gray-style encoding: bit 1 is the debounced level in every state.
    typedef enum logic [1:0] {
        S_LOW      = 2'b00,
        S_LOW2HIGH = 2'b01,
        S_HIGH     = 2'b11,
        S_HIGH2LOW = 2'b10
    } jk_state_t;

    localparam int JK_SYNC_STAGES   = 2;
    localparam int JK_STABLE_CYCLES = 4;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : bit_synchronizer
// Purpose  : Multi-flop single-bit synchroniser with synchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module bit_synchronizer
    import jk_pkg::*;
#(
    parameter int STAGES = JK_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : bit_synchronizer
`default_nettype wire

// File: rtl/jk_q_monitor.sv
`default_nettype none
// ============================================================================
// Module   : jk_q_monitor
// Purpose  : Synchronises and debounces the JK latch output, emitting edge
//            pulses, a saturating edge count and high-pulse width.
// Revision : 1.0  initial release
// ============================================================================
module jk_q_monitor
    import jk_pkg::*;
#(
    parameter int SYNC_STAGES   = JK_SYNC_STAGES,
    parameter int STABLE_CYCLES = JK_STABLE_CYCLES,
    parameter int CNT_W         = 8,
    parameter int WIDTH_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_in,
    input  logic               clr_cnt,
    output logic               q_filt,
    output logic               rise,
    output logic               fall,
    output logic [CNT_W-1:0]   edge_cnt,
    output logic               cnt_sat,
    output logic [WIDTH_W-1:0] hi_width,
    output logic               width_valid
);

    localparam int                c_stab_w   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_stab_w-1:0] c_stab_max = c_stab_w'(STABLE_CYCLES);
    localparam logic [c_stab_w-1:0] c_stab_one = c_stab_w'(1);

    logic                w_q_sync;
    jk_state_t           r_state;
    jk_state_t           w_state_nxt;
    logic [c_stab_w-1:0] r_stab;
    logic [c_stab_w-1:0] w_stab_nxt;
    logic                w_rise_nxt;
    logic                w_fall_nxt;
    logic                r_rise;
    logic                r_fall;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_edge;
    logic [WIDTH_W-1:0]  r_width;
    logic [WIDTH_W-1:0]  w_width_inc;
    logic [WIDTH_W-1:0]  r_hi_width;
    logic                r_width_valid;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (q_in),
        .q   (w_q_sync)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
            r_stab  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stab  <= w_stab_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab;
        case (r_state)
            S_LOW: begin
                if (w_q_sync) begin
                    w_state_nxt = S_LOW2HIGH;
                    w_stab_nxt  = c_stab_one;
                end
            end
            S_LOW2HIGH: begin
                if (!w_q_sync) begin
                    w_state_nxt = S_LOW;
                    w_stab_nxt  = '0;
                end else if (r_stab == c_stab_max) begin
                    w_state_nxt = S_HIGH;
                    w_stab_nxt  = '0;
                end else begin
                    w_stab_nxt  = r_stab + c_stab_one;
                end
            end
            S_HIGH: begin
                if (!w_q_sync) begin
                    w_state_nxt = S_HIGH2LOW;
                    w_stab_nxt  = c_stab_one;
                end
            end
            S_HIGH2LOW: begin
                if (w_q_sync) begin
                    w_state_nxt = S_HIGH;
                    w_stab_nxt  = '0;
                end else if (r_stab == c_stab_max) begin
                    w_state_nxt = S_LOW;
                    w_stab_nxt  = '0;
                end else begin
                    w_stab_nxt  = r_stab + c_stab_one;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_stab_nxt  = '0;
            end
        endcase
    end

    assign w_rise_nxt = (r_state == S_LOW2HIGH) && (w_state_nxt == S_HIGH);
    assign w_fall_nxt = (r_state == S_HIGH2LOW) && (w_state_nxt == S_LOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Saturating edge counter; counts the cycle in which a pulse is visible
    // ------------------------------------------------------------------
    assign w_edge = r_rise | r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= CNT_W'(w_edge);
        end else if (w_edge && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // High-pulse width; the fall cycle itself is included in the capture
    // ------------------------------------------------------------------
    assign w_width_inc = (&r_width) ? r_width : r_width + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width       <= '0;
            r_hi_width    <= '0;
            r_width_valid <= 1'b0;
        end else begin
            r_width_valid <= w_fall_nxt;
            if (w_rise_nxt) begin
                r_width <= '0;
            end else if (r_state[1]) begin
                r_width <= w_width_inc;
            end
            if (w_fall_nxt) begin
                r_hi_width <= w_width_inc;
            end
        end
    end

    assign q_filt      = r_state[1];
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign edge_cnt    = r_cnt;
    assign cnt_sat     = &r_cnt;
    assign hi_width    = r_hi_width;
    assign width_valid = r_width_valid;

endmodule : jk_q_monitor
`default_nettype wire
